// File: rtl/multi_gate_unit_if.sv
// Handshake and data bundle for multi_gate_unit: operand beats in, results out.
interface multi_gate_unit_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_mode;
  logic             acc_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_par;
  logic [CNT_W-1:0] beat_cnt;

  // Producer/consumer side that drives operands and accepts results
  modport master (
    output in_valid, a, b, op, acc_mode, acc_last, out_ready,
    input  in_ready, out_valid, y, y_par, beat_cnt
  );

  // The logic unit itself
  modport slave (
    input  in_valid, a, b, op, acc_mode, acc_last, out_ready,
    output in_ready, out_valid, y, y_par, beat_cnt
  );
endinterface

// File: rtl/multi_gate_unit.sv
// Registered WIDTH-bit bitwise logic unit with 8-way op select and an
// accumulate mode that folds a multi-beat stream into a single result.
module multi_gate_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  multi_gate_unit_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       state;
  logic [WIDTH-1:0] acc;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] y_q;
  logic [CNT_W-1:0] beat_q;
  logic             out_valid_q;

  logic             in_ready;
  logic             accept;
  logic             start_stream;
  logic             load;
  logic [2:0]       fold_op;
  logic [WIDTH-1:0] fold_x;
  logic [WIDTH-1:0] fold_z;
  logic [WIDTH-1:0] r;
  logic [CNT_W-1:0] cnt_next;

  function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] z,
                                            input logic [2:0]       sel);
    case (sel)
      3'd0:    return x & z;
      3'd1:    return x | z;
      3'd2:    return x ^ z;
      3'd3:    return ~(x & z);
      3'd4:    return ~(x | z);
      3'd5:    return ~(x ^ z);
      3'd6:    return ~x;
      default: return x;
    endcase
  endfunction

  // Ready depends only on the output register and downstream, never on in_valid
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // In ACCUM the running value is folded with a under the latched op; in IDLE a meets b
  always_comb begin
    fold_op      = bus.op;
    fold_x       = bus.a;
    fold_z       = bus.b;
    cnt_next     = CNT_ONE;
    start_stream = 1'b0;
    load         = 1'b0;
    if (state == ACCUM) begin
      fold_op  = op_q;
      fold_x   = acc;
      fold_z   = bus.a;
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      load     = accept && bus.acc_last;
    end else begin
      start_stream = accept && bus.acc_mode && !bus.acc_last;
      load         = accept && !start_stream;
    end
    r = gate(fold_x, fold_z, fold_op);
  end

  // Stream state: open a stream, keep folding non-last beats, close on the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      op_q  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      if (start_stream) begin
        state <= ACCUM;
        acc   <= r;
        op_q  <= bus.op;
        cnt   <= CNT_ONE;
      end else if (state == ACCUM) begin
        if (bus.acc_last) begin
          state <= IDLE;
        end else begin
          acc <= r;
          cnt <= cnt_next;
        end
      end
    end
  end

  // Output register: a load wins over a drain so back-to-back results leave no bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q         <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
    end else if (load) begin
      y_q         <= r;
      beat_q      <= cnt_next;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.y_par     = ^y_q;
  assign bus.beat_cnt  = beat_q;
endmodule

// File: tb/tb_multi_gate_unit.sv
// Self-checking bench for multi_gate_unit: two instances (CNT_W=8 and CNT_W=2)
// share one stimulus stream and are compared against a stream-level model.
module tb_multi_gate_unit;
  logic clk = 1'b0;
  logic rst;
  logic in_valid, acc_mode, acc_last, out_ready;
  logic [7:0] a, b;
  logic [2:0] op;

  always #5 clk = ~clk;

  multi_gate_unit_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
  multi_gate_unit_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  assign bus8.in_valid = in_valid;
  assign bus8.a = a;
  assign bus8.b = b;
  assign bus8.op = op;
  assign bus8.acc_mode = acc_mode;
  assign bus8.acc_last = acc_last;
  assign bus8.out_ready = out_ready;
  assign bus2.in_valid = in_valid;
  assign bus2.a = a;
  assign bus2.b = b;
  assign bus2.op = op;
  assign bus2.acc_mode = acc_mode;
  assign bus2.acc_last = acc_last;
  assign bus2.out_ready = out_ready;

  multi_gate_unit #(.WIDTH(8), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  multi_gate_unit #(.WIDTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int errors = 0;
  int checks = 0;

  // Reference model: remembers the whole open stream and folds it when it closes
  logic       exp_valid;
  logic [7:0] exp_y;
  int         exp_cnt;
  bit         in_stream;
  logic [2:0] s_op;
  logic [7:0] s_first;
  logic [7:0] s_beats[$];

  function automatic logic [7:0] gate(input logic [7:0] x, input logic [7:0] z, input logic [2:0] o);
    case (o)
      3'd0: return x & z;
      3'd1: return x | z;
      3'd2: return x ^ z;
      3'd3: return ~(x & z);
      3'd4: return ~(x | z);
      3'd5: return ~(x ^ z);
      3'd6: return ~x;
      default: return x;
    endcase
  endfunction

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic bit exp_ready();
    return !exp_valid || out_ready;
  endfunction

  // Advance one clock, updating the model with what the DUT should have done
  task automatic step();
    bit take;
    bit loaded;
    logic [7:0] r;
    take = !rst && in_valid && exp_ready();
    loaded = 0;
    @(posedge clk);
    if (rst) begin
      exp_valid = 0;
      exp_y = 8'h00;
      exp_cnt = 0;
      in_stream = 0;
      s_beats.delete();
    end else begin
      if (take) begin
        if (!in_stream) begin
          if (acc_mode && !acc_last) begin
            in_stream = 1;
            s_op = op;
            s_first = gate(a, b, op);
            s_beats.delete();
          end else begin
            exp_y = gate(a, b, op);
            exp_cnt = 1;
            loaded = 1;
          end
        end else begin
          s_beats.push_back(a);
          if (acc_last) begin
            r = s_first;
            foreach (s_beats[i]) r = gate(r, s_beats[i], s_op);
            exp_y = r;
            exp_cnt = 1 + s_beats.size();
            loaded = 1;
            in_stream = 0;
          end
        end
      end
      if (loaded) exp_valid = 1;
      else if (exp_valid && out_ready) exp_valid = 0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0;
    acc_mode = 0;
    acc_last = 0;
    a = 8'h00;
    b = 8'h00;
    op = 3'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    out_ready = 0;
    rst = 1;
    step();
    step();
    checks += 5;
    if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus8.out_valid); end
    if (bus8.y !== 8'h00) begin errors++; $display("[TB] FAIL reset_y got=%h want=00", bus8.y); end
    if (bus8.beat_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_beat_cnt got=%0d want=0", bus8.beat_cnt); end
    if (bus8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b want=1", bus8.in_ready); end
    if (bus2.out_valid !== 1'b0 || bus2.y_par !== 1'b0) begin errors++; $display("[TB] FAIL reset_dut2 got valid=%b par=%b want 0/0", bus2.out_valid, bus2.y_par); end
    rst = 0;
  endtask

  task automatic test_all_ops();
    logic [7:0] tbl [8];
    tbl = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'h0F, 8'hF0};
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; acc_mode = 0; acc_last = 0;
      a = 8'hF0; b = 8'hCC; op = 3'(i);
      step();
      checks += 4;
      if (bus8.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL op%0d_valid got=%b want=1", i, bus8.out_valid); end
      if (bus8.y !== tbl[i]) begin errors++; $display("[TB] FAIL op%0d_y got=%h want=%h", i, bus8.y, tbl[i]); end
      if (bus8.beat_cnt !== 8'd1) begin errors++; $display("[TB] FAIL op%0d_cnt got=%0d want=1", i, bus8.beat_cnt); end
      if (bus8.y_par !== ^tbl[i]) begin errors++; $display("[TB] FAIL op%0d_par got=%b want=%b", i, bus8.y_par, ^tbl[i]); end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_xor_accum();
    out_ready = 1;
    in_valid = 1; acc_mode = 1; acc_last = 0; op = 3'd2; a = 8'h01; b = 8'h02;
    step();
    checks++;
    if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL acc_beat1_valid got=%b want=0", bus8.out_valid); end
    op = 3'd0; a = 8'h04; b = 8'hFF;
    step();
    checks++;
    if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL acc_beat2_valid got=%b want=0", bus8.out_valid); end
    op = 3'd1; a = 8'h08; acc_last = 1;
    step();
    checks += 4;
    if (bus8.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL acc_valid got=%b want=1", bus8.out_valid); end
    if (bus8.y !== 8'h0F) begin errors++; $display("[TB] FAIL acc_y got=%h want=0f", bus8.y); end
    if (bus8.beat_cnt !== 8'd3 || bus2.beat_cnt !== 2'd3) begin errors++; $display("[TB] FAIL acc_cnt got=%0d/%0d want=3/3", bus8.beat_cnt, bus2.beat_cnt); end
    if (bus8.y_par !== 1'b0) begin errors++; $display("[TB] FAIL acc_par got=%b want=0", bus8.y_par); end
    idle_inputs();
    step();
    checks++;
    if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL acc_single_result got=%b want=0", bus8.out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1;
    in_valid = 1; acc_mode = 0; acc_last = 0; op = 3'd2; a = 8'h5A; b = 8'h0F;
    step();
    out_ready = 0;
    op = 3'd0; a = 8'h33; b = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks += 2;
      if (bus8.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready cyc%0d got=%b want=0", i, bus8.in_ready); end
      step();
      if (bus8.y !== 8'h55 || bus8.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold cyc%0d got y=%h v=%b want y=55 v=1", i, bus8.y, bus8.out_valid); end
    end
    out_ready = 1;
    #1;
    checks++;
    if (bus8.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got=%b want=1", bus8.in_ready); end
    step();
    checks += 2;
    if (bus8.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_reload_valid got=%b want=1", bus8.out_valid); end
    if (bus8.y !== 8'h03) begin errors++; $display("[TB] FAIL bp_reload_y got=%h want=03", bus8.y); end
    idle_inputs();
    step();
    checks++;
    if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got=%b want=0", bus8.out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1;
    in_valid = 1; acc_mode = 1; acc_last = 0; op = 3'd1; a = 8'h11; b = 8'h22;
    step();
    a = 8'h44;
    step();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    checks++;
    if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid got=%b want=0", bus8.out_valid); end
    in_valid = 1; acc_mode = 0; op = 3'd0; a = 8'hFF; b = 8'h55;
    step();
    checks += 2;
    if (bus8.out_valid !== 1'b1 || bus8.y !== 8'h55) begin errors++; $display("[TB] FAIL mid_rst_y got v=%b y=%h want v=1 y=55", bus8.out_valid, bus8.y); end
    if (bus8.beat_cnt !== 8'd1) begin errors++; $display("[TB] FAIL mid_rst_cnt got=%0d want=1", bus8.beat_cnt); end
    idle_inputs();
    step();
    checks++;
    if (bus8.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_extra got=%b want=0", bus8.out_valid); end
  endtask

  task automatic test_saturation();
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; acc_mode = 1; acc_last = (i == 5); op = 3'd1;
      a = 8'(1 << i); b = 8'h00;
      step();
    end
    checks += 3;
    if (bus2.y !== 8'h3F || bus8.y !== 8'h3F) begin errors++; $display("[TB] FAIL sat_y got=%h/%h want=3f", bus8.y, bus2.y); end
    if (bus2.beat_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat_cnt2 got=%0d want=3", bus2.beat_cnt); end
    if (bus8.beat_cnt !== 8'd6) begin errors++; $display("[TB] FAIL sat_cnt8 got=%0d want=6", bus8.beat_cnt); end
    idle_inputs();
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      acc_mode = $urandom_range(0, 1) == 1;
      acc_last = ($urandom_range(0, 9) < 3);
      out_ready = ($urandom_range(0, 9) < 7);
      a = 8'($urandom);
      b = 8'($urandom);
      op = 3'($urandom_range(0, 7));
      #1;
      checks += 2;
      if (bus8.in_ready !== exp_ready()) begin errors++; $display("[TB] FAIL rnd_in_ready8 n=%0d got=%b want=%b", n, bus8.in_ready, exp_ready()); end
      if (bus2.in_ready !== exp_ready()) begin errors++; $display("[TB] FAIL rnd_in_ready2 n=%0d got=%b want=%b", n, bus2.in_ready, exp_ready()); end
      step();
      checks++;
      if (bus8.out_valid !== exp_valid || bus2.out_valid !== exp_valid) begin errors++; $display("[TB] FAIL rnd_valid n=%0d got=%b/%b want=%b", n, bus8.out_valid, bus2.out_valid, exp_valid); end
      if (exp_valid) begin
        checks += 4;
        if (bus8.y !== exp_y || bus2.y !== exp_y) begin errors++; $display("[TB] FAIL rnd_y n=%0d got=%h/%h want=%h", n, bus8.y, bus2.y, exp_y); end
        if (bus8.y_par !== ^exp_y) begin errors++; $display("[TB] FAIL rnd_par n=%0d got=%b want=%b", n, bus8.y_par, ^exp_y); end
        if (int'(bus8.beat_cnt) != sat(exp_cnt, 8)) begin errors++; $display("[TB] FAIL rnd_cnt8 n=%0d got=%0d want=%0d", n, bus8.beat_cnt, sat(exp_cnt, 8)); end
        if (int'(bus2.beat_cnt) != sat(exp_cnt, 2)) begin errors++; $display("[TB] FAIL rnd_cnt2 n=%0d got=%0d want=%0d", n, bus2.beat_cnt, sat(exp_cnt, 2)); end
      end
    end
    rst = 0;
  endtask

  // Scenario sequence followed by the single summary line
  initial begin
    exp_valid = 0;
    exp_y = 8'h00;
    exp_cnt = 0;
    in_stream = 0;
    s_op = 3'd0;
    s_first = 8'h00;
    rst = 1;
    out_ready = 0;
    idle_inputs();
    test_reset();
    test_all_ops();
    test_xor_accum();
    test_backpressure();
    test_reset_midstream();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
